// File: rtl/bus_dma_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bus_dma_pkg
// Brief    : Bus IDs, control-word bit positions and FSM encoding shared by
//            the DMA engine and its sub-blocks.
// Revision : 1.0 - initial release
// ============================================================================
package bus_dma_pkg;

    typedef enum logic [2:0] {
        ID_RAM  = 3'd0,
        ID_ROM  = 3'd1,
        ID_VGA  = 3'd2,
        ID_PS2  = 3'd3,
        ID_ACP  = 3'd4,
        ID_DMA  = 3'd5,
        ID_UART = 3'd6,
        ID_CPU  = 3'd7
    } bus_id_e;

    localparam int c_CTRL_ID_HI = 7;
    localparam int c_CTRL_ID_LO = 5;
    localparam int c_CTRL_WR    = 4;
    localparam int c_CTRL_VALID = 3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_RD_ADDR = 3'd2,
        S_RD_WAIT = 3'd3,
        S_WR_ADDR = 3'd4,
        S_WR_DATA = 3'd5,
        S_NEXT    = 3'd6,
        S_DONE    = 3'd7
    } dma_state_e;

    function automatic logic [7:0] make_ctrl(input logic [2:0] dev, input logic wr);
        logic [7:0] c;
        c                             = 8'h00;
        c[c_CTRL_ID_HI:c_CTRL_ID_LO]  = dev;
        c[c_CTRL_WR]                  = wr;
        c[c_CTRL_VALID]               = 1'b1;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_dma_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module   : bus_dma_timeout_counter
// Brief    : Read-response watchdog: load clears, enable counts, holds at
//            TIMEOUT and flags expiry while there.
// Revision : 1.0 - initial release
// ============================================================================
module bus_dma_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int c_CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [c_CNT_W-1:0] cnt_q;
    logic [c_CNT_W-1:0] cnt_d;

    assign expired_o = (cnt_q == c_CNT_W'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + c_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_dma.sv
`default_nettype none
// ============================================================================
// Module   : bus_dma
// Brief    : Single-channel bus-master DMA; copies cfg_len words from a source
//            device/address to a destination via the shared req/ack bus.
//            Build option DMA_YIELD_EN: release the bus for one cycle per word.
// Revision : 1.0 - initial release
// ============================================================================
module bus_dma
    import bus_dma_pkg::*;
#(
    parameter int         D_WIDTH    = 32,
    parameter int         C_WIDTH    = 8,
    parameter int         A_WIDTH    = 24,
    parameter int         L_WIDTH    = 16,
    parameter logic [2:0] DMA_BUS_ID = ID_DMA,
    parameter int         TIMEOUT    = 255
) (
    input  logic               clk25MHz,
    input  logic               reset,
    input  logic [2:0]         cfg_src_dev,
    input  logic [A_WIDTH-1:0] cfg_src_addr,
    input  logic [2:0]         cfg_dst_dev,
    input  logic [A_WIDTH-1:0] cfg_dst_addr,
    input  logic [L_WIDTH-1:0] cfg_len,
    input  logic               cfg_start,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               bus_req,
    input  logic               bus_ack,
    input  logic [D_WIDTH-1:0] bus_data_in,
    input  logic [C_WIDTH-1:0] bus_ctrl_in,
    output logic [D_WIDTH-1:0] bus_data_out,
    output logic [C_WIDTH-1:0] bus_ctrl_out
);

`ifdef DMA_YIELD_EN
    localparam bit c_YIELD = 1'b1;
`else
    localparam bit c_YIELD = 1'b0;
`endif

    dma_state_e         state_q, state_d;
    logic [2:0]         src_dev_q, src_dev_d;
    logic [2:0]         dst_dev_q, dst_dev_d;
    logic [A_WIDTH-1:0] src_addr_q, src_addr_d;
    logic [A_WIDTH-1:0] dst_addr_q, dst_addr_d;
    logic [L_WIDTH-1:0] count_q, count_d;
    logic [D_WIDTH-1:0] hold_q, hold_d;
    logic               error_q, error_d;
    logic               bus_req_q, bus_req_d;
    logic               tmo_load, tmo_en, tmo_expired;
    logic               rsp_hit;
    logic               unused_ctrl;

    assign rsp_hit = bus_ctrl_in[c_CTRL_VALID]
                  && (bus_ctrl_in[c_CTRL_ID_HI:c_CTRL_ID_LO] == DMA_BUS_ID);
    assign unused_ctrl = ^bus_ctrl_in;

    bus_dma_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk_i     (clk25MHz),
        .rst_i     (reset),
        .load_i    (tmo_load),
        .en_i      (tmo_en),
        .expired_o (tmo_expired)
    );

    // Bus states only advance while granted; without bus_ack everything holds
    // and the bus outputs stay zero. NEXT touches no bus signals.
    always_comb begin
        state_d      = state_q;
        src_dev_d    = src_dev_q;
        dst_dev_d    = dst_dev_q;
        src_addr_d   = src_addr_q;
        dst_addr_d   = dst_addr_q;
        count_d      = count_q;
        hold_d       = hold_q;
        error_d      = error_q;
        tmo_load     = 1'b0;
        tmo_en       = 1'b0;
        bus_data_out = '0;
        bus_ctrl_out = '0;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    src_dev_d  = cfg_src_dev;
                    dst_dev_d  = cfg_dst_dev;
                    src_addr_d = cfg_src_addr;
                    dst_addr_d = cfg_dst_addr;
                    count_d    = cfg_len;
                    error_d    = 1'b0;
                    state_d    = (cfg_len == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (bus_ack) state_d = S_RD_ADDR;
            end
            S_RD_ADDR: begin
                if (bus_ack) begin
                    bus_data_out = D_WIDTH'(src_addr_q);
                    bus_ctrl_out = C_WIDTH'(make_ctrl(src_dev_q, 1'b0));
                    tmo_load     = 1'b1;
                    state_d      = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // A response in the expiry cycle still counts as success.
                if (bus_ack) begin
                    if (rsp_hit) begin
                        hold_d  = bus_data_in;
                        state_d = S_WR_ADDR;
                    end else if (tmo_expired) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        tmo_en  = 1'b1;
                    end
                end
            end
            S_WR_ADDR: begin
                if (bus_ack) begin
                    bus_data_out = D_WIDTH'(dst_addr_q);
                    bus_ctrl_out = C_WIDTH'(make_ctrl(dst_dev_q, 1'b1));
                    state_d      = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (bus_ack) begin
                    bus_data_out = hold_q;
                    bus_ctrl_out = C_WIDTH'(make_ctrl(dst_dev_q, 1'b1));
                    state_d      = S_NEXT;
                end
            end
            S_NEXT: begin
                src_addr_d = src_addr_q + A_WIDTH'(1);
                dst_addr_d = dst_addr_q + A_WIDTH'(1);
                count_d    = count_q - L_WIDTH'(1);
                if (count_q == L_WIDTH'(1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = c_YIELD ? S_REQ : S_RD_ADDR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        unique case (state_d)
            S_REQ, S_RD_ADDR, S_RD_WAIT, S_WR_ADDR, S_WR_DATA: bus_req_d = 1'b1;
            S_NEXT:                                            bus_req_d = !c_YIELD;
            default:                                           bus_req_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk25MHz) begin
        if (reset) begin
            state_q    <= S_IDLE;
            src_dev_q  <= '0;
            dst_dev_q  <= '0;
            src_addr_q <= '0;
            dst_addr_q <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            error_q    <= 1'b0;
            bus_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_dev_q  <= src_dev_d;
            dst_dev_q  <= dst_dev_d;
            src_addr_q <= src_addr_d;
            dst_addr_q <= dst_addr_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
            error_q    <= error_d;
            bus_req_q  <= bus_req_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign error   = error_q;
    assign bus_req = bus_req_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_dma
// Brief    : Self-checking bench for bus_dma: bus arbiter, read responder with
//            programmable latency, write scoreboard. Honours DMA_YIELD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_dma;

    localparam int         A_W    = 24;
    localparam int         L_W    = 16;
    localparam int         TMO    = 255;
    localparam logic [2:0] DMA_ID = 3'd5;
`ifdef DMA_YIELD_EN
    localparam bit YIELD = 1'b1;
`else
    localparam bit YIELD = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  dev;
        logic [23:0] addr;
        logic [31:0] data;
    } wr_t;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [2:0]     cfg_src_dev = '0;
    logic [A_W-1:0] cfg_src_addr = '0;
    logic [2:0]     cfg_dst_dev = '0;
    logic [A_W-1:0] cfg_dst_addr = '0;
    logic [L_W-1:0] cfg_len = '0;
    logic           cfg_start = 1'b0;
    logic           busy, done, error, bus_req, bus_ack;
    logic [31:0]    bus_data_in = '0;
    logic [31:0]    bus_data_out;
    logic [7:0]     bus_ctrl_in = '0;
    logic [7:0]     bus_ctrl_out;
    logic           gap = 1'b0;

    wr_t exp_q[$];
    int  n_cmp = 0, n_bad = 0;
    int  cyc = 0, req_low = 0;
    bit  rsp_en = 1'b1, rd_seen = 1'b0;
    int  rsp_lat = 2, gap_word = -1, gap_cyc = 0, word_idx = 0;

    assign bus_ack = bus_req & ~gap;

    always #20 clk = ~clk;
    always @(posedge clk) cyc++;

    bus_dma #(.TIMEOUT(TMO)) dut (
        .clk25MHz     (clk),
        .reset        (reset),
        .cfg_src_dev  (cfg_src_dev),
        .cfg_src_addr (cfg_src_addr),
        .cfg_dst_dev  (cfg_dst_dev),
        .cfg_dst_addr (cfg_dst_addr),
        .cfg_len      (cfg_len),
        .cfg_start    (cfg_start),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .bus_req      (bus_req),
        .bus_ack      (bus_ack),
        .bus_data_in  (bus_data_in),
        .bus_ctrl_in  (bus_ctrl_in),
        .bus_data_out (bus_data_out),
        .bus_ctrl_out (bus_ctrl_out)
    );

    // Contents of every readable device: a fixed scramble of ID and address.
    function automatic logic [31:0] mem_word(input logic [2:0] dev, input logic [23:0] a);
        return {dev, 5'b10110, a} ^ 32'h3C5A_0F96;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Read responder plus grant-gap injector, acting as the slave devices.
    initial begin : responder
        logic [2:0]  r_dev;
        logic [23:0] r_addr;
        int          r_lat, r_gap;
        forever begin
            @(negedge clk);
            if (!reset && bus_ack && bus_ctrl_out[3] && !bus_ctrl_out[4]) begin
                rd_seen = 1'b1;
                if (rsp_en) begin
                    r_dev  = bus_ctrl_out[7:5];
                    r_addr = bus_data_out[23:0];
                    r_lat  = rsp_lat;
                    r_gap  = (word_idx == gap_word) ? gap_cyc : 0;
                    word_idx++;
                    for (int j = 1; j < r_lat; j++) begin
                        @(negedge clk);
                        bus_ctrl_in = (j == 1) ? {DMA_ID ^ 3'b001, 5'b01000} : 8'h00;
                        bus_data_in = 32'hDEAD_BEEF;
                    end
                    @(negedge clk);
                    bus_ctrl_in = {DMA_ID, 5'b01000};
                    bus_data_in = mem_word(r_dev, r_addr);
                    @(posedge clk);
                    #1;
                    bus_ctrl_in = 8'h00;
                    bus_data_in = 32'h0;
                    if (r_gap > 0) begin
                        gap = 1'b1;
                        repeat (r_gap) @(posedge clk);
                        #1 gap = 1'b0;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: pairs write-address and write-data cycles.
    initial begin : monitor
        bit          phase;
        logic [2:0]  wdev;
        logic [23:0] waddr;
        wr_t         e;
        phase = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                phase = 1'b0;
            end else begin
                if (busy && !bus_req) req_low++;
                if (busy && !bus_ack) begin
                    chk("ungranted_ctrl", bus_ctrl_out, 0);
                    chk("ungranted_data", bus_data_out, 0);
                end
                if (bus_ack && bus_ctrl_out[3] && bus_ctrl_out[4]) begin
                    if (!phase) begin
                        wdev  = bus_ctrl_out[7:5];
                        waddr = bus_data_out[23:0];
                        chk("wr_addr_upper", bus_data_out[31:24], 0);
                        phase = 1'b1;
                    end else begin
                        phase = 1'b0;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_write", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("wr_dev", wdev, e.dev);
                            chk("wr_addr", waddr, e.addr);
                            chk("wr_data", bus_data_out, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic run_xfer(input logic [2:0] sd, input logic [23:0] sa,
                            input logic [2:0] dd, input logic [23:0] da,
                            input int len, input int lat, input int gw, input int gc,
                            input bit to, input bit poke);
        int  exp_cyc, exp_low, start_cyc;
        bit  seen;
        wr_t w;
        if (!to) begin
            for (int i = 0; i < len; i++) begin
                w.dev  = dd;
                w.addr = da + 24'(i);
                w.data = mem_word(sd, sa + 24'(i));
                exp_q.push_back(w);
            end
        end
        if (len == 0) begin
            exp_cyc = 1;
            exp_low = 1;
        end else if (to) begin
            exp_cyc = TMO + 4;
            exp_low = 1;
        end else begin
            exp_cyc = 2 + len * (4 + lat) + ((gw < len) ? gc : 0) + (YIELD ? len - 1 : 0);
            exp_low = YIELD ? len + 1 : 1;
        end
        rsp_en = !to; rsp_lat = lat; gap_word = gw; gap_cyc = gc; word_idx = 0;
        @(negedge clk);
        cfg_src_dev = sd; cfg_src_addr = sa; cfg_dst_dev = dd; cfg_dst_addr = da;
        cfg_len = L_W'(len); cfg_start = 1'b1;
        start_cyc = cyc; req_low = 0;
        @(negedge clk);
        cfg_start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < exp_cyc + 64; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (poke && k == 3) begin
                cfg_src_addr = ~sa; cfg_len = 16'd9; cfg_start = 1'b1;
            end else begin
                cfg_start = 1'b0;
            end
            @(negedge clk);
        end
        cfg_start = 1'b0;
        chk("done_seen", seen, 1);
        if (seen) begin
            chk("done_latency", cyc - start_cyc, exp_cyc);
            chk("busy_at_done", busy, 1);
            chk("error_at_done", error, to);
            chk("pending_writes", exp_q.size(), 0);
            @(negedge clk);
            chk("req_low_cycles", req_low, exp_low);
            chk("busy_after", busy, 0);
            chk("done_after", done, 0);
            chk("req_after", bus_req, 0);
        end else begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic reset_midway();
        rsp_en = 1'b1; rsp_lat = 12; gap_word = -1; gap_cyc = 0; word_idx = 0; rd_seen = 1'b0;
        @(negedge clk);
        cfg_src_dev = 3'd0; cfg_src_addr = 24'h000400; cfg_dst_dev = 3'd2;
        cfg_dst_addr = 24'h000010; cfg_len = 16'd3; cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (rd_seen) break;
            @(negedge clk);
        end
        chk("rst_read_issued", rd_seen, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk("rst_no_done", done, 0);
        end
    endtask

    initial begin : stimulus
        int len;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_error", error, 0);
        chk("reset_req", bus_req, 0);
        chk("reset_data_out", bus_data_out, 0);
        chk("reset_ctrl_out", bus_ctrl_out, 0);
        reset = 1'b0;

        run_xfer(3'd0, 24'h000100, 3'd2, 24'h000000, 4, 2, -1, 0, 1'b0, 1'b0);
        run_xfer(3'd0, 24'h000005, 3'd2, 24'h000009, 0, 2, -1, 0, 1'b0, 1'b0);
        run_xfer(3'd0, 24'hFFFFFF, 3'd6, 24'h000010, 2, 1, -1, 0, 1'b0, 1'b0);
        run_xfer(3'd6, 24'h000020, 3'd0, 24'h000040, 2, 1, -1, 0, 1'b1, 1'b0);
        reset_midway();
        run_xfer(3'd0, 24'h000300, 3'd2, 24'hFFFFFE, 3, 2, 1, 5, 1'b0, 1'b1);

        for (int t = 0; t < 14; t++) begin
            len = int'($urandom_range(1, 6));
            run_xfer(3'($urandom_range(0, 7)),
                     ($urandom_range(0, 3) == 0) ? 24'hFFFFFF - 24'($urandom_range(0, 3))
                                                 : 24'($urandom),
                     3'($urandom_range(0, 7)), 24'($urandom),
                     len, int'($urandom_range(1, 4)), int'($urandom_range(0, len)),
                     int'($urandom_range(0, 5)), 1'b0, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
